// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the sine-wave generator chain
// (phase sequencer and serialiser).
package sine_pkg;

  localparam int PHASE_W_DEF  = 24;
  localparam int ADDR_W_DEF   = 8;
  localparam int TICK_DIV_DEF = 32;
  localparam int ROM_LAT_DEF  = 1;

  localparam logic [1:0] STATE_IDLE     = 2'd0;
  localparam logic [1:0] STATE_RUN      = 2'd1;
  localparam logic [1:0] STATE_STOPPING = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = STATE_IDLE,
    ST_RUN      = STATE_RUN,
    ST_STOPPING = STATE_STOPPING
  } seq_state_e;

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Control and sample-address bundle between the phase sequencer and its
// controller. The master drives the run/tuning controls.
interface sine_phase_sequencer_if
  import sine_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
);

  logic               en;
  logic [PHASE_W-1:0] tw;
  logic               tw_load;
  logic               phase_clr;
  logic               tick;
  logic [ADDR_W-1:0]  rom_addr;
  logic               negate;
  logic               busy;

  modport master (
    output en, tw, tw_load, phase_clr,
    input  tick, rom_addr, negate, busy
  );

  modport slave (
    input  en, tw, tw_load, phase_clr,
    output tick, rom_addr, negate, busy
  );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with asynchronous clear; depth 0 is a
// straight wire.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift each stage one step down the line.
    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sine_phase_sequencer.sv
// DDS phase accumulator and frame sequencer: one quarter-wave ROM address
// per TICK_DIV-clock frame, with a sign flag aligned to the ROM output.
module sine_phase_sequencer
  import sine_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int ROM_LAT  = ROM_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sine_phase_sequencer_if.slave  bus
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] tw_shadow_q, tw_shadow_d;
  logic [PHASE_W-1:0] tw_active_q, tw_active_d;
  logic               clr_pend_q, clr_pend_d;
  logic               tick_q, tick_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               negate_pre_q, negate_pre_d;
  logic               busy_q, busy_d;

  logic               frame_wrap;
  logic [PHASE_W-1:0] phase_sum;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  fine_addr;
  logic [ADDR_W-1:0]  folded_addr;
  logic               negate_dly;

  // Odd quadrants read the table backwards; the upper quadrant bit is the sign.
  assign phase_sum   = clr_pend_q ? '0 : (phase_q + tw_active_q);
  assign quad        = phase_sum[PHASE_W-1 -: 2];
  assign fine_addr   = phase_sum[PHASE_W-3 -: ADDR_W];
  assign folded_addr = quad[0] ? ~fine_addr : fine_addr;

  // Frame counter, run/stop sequencing and frame-boundary phase update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    tw_active_d  = tw_active_q;
    rom_addr_d   = rom_addr_q;
    negate_pre_d = negate_pre_q;
    tick_d       = 1'b0;
    frame_wrap   = 1'b0;
    tw_shadow_d  = bus.tw_load ? bus.tw : tw_shadow_q;
    clr_pend_d   = clr_pend_q | bus.phase_clr;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (cnt_q == CNT_LAST) begin
          frame_wrap = 1'b1;
          cnt_d      = '0;
          state_d    = bus.en ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = bus.en ? ST_RUN : ST_STOPPING;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A clear strobe landing on the boundary itself is kept for the next frame.
    if (frame_wrap) begin
      tick_d       = 1'b1;
      phase_d      = phase_sum;
      clr_pend_d   = bus.phase_clr;
      tw_active_d  = tw_shadow_q;
      rom_addr_d   = folded_addr;
      negate_pre_d = quad[1];
    end else begin
      tick_d       = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      tw_shadow_q  <= '0;
      tw_active_q  <= '0;
      clr_pend_q   <= 1'b0;
      tick_q       <= 1'b0;
      rom_addr_q   <= '0;
      negate_pre_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      tw_shadow_q  <= tw_shadow_d;
      tw_active_q  <= tw_active_d;
      clr_pend_q   <= clr_pend_d;
      tick_q       <= tick_d;
      rom_addr_q   <= rom_addr_d;
      negate_pre_q <= negate_pre_d;
      busy_q       <= busy_d;
    end
  end

  delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (1)
  ) u_negate_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (negate_pre_q),
    .dout  (negate_dly)
  );

  assign bus.tick     = tick_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.negate   = negate_dly;
  assign bus.busy     = busy_q;

endmodule
